// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, 3-point majority sampling, LSB-first
// deserialization, parity/stop checking and result strobes. Drives an external edge/bit counter.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [3:0]            bit_cnt,
    input  logic [5:0]            edge_cnt,
    output logic                  cnt_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxs;
    logic [2:0]              cap_q;
    logic                    samp;
    logic [5:0]              half;
    logic                    bit_end;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    perr_q;
    logic [DATA_WIDTH-1:0]   shift_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign half    = {1'b0, prescale[5:1]};
    assign bit_end = (edge_cnt == prescale - 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q <= '0;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) cap_q[0] <= rxs;
            if (edge_cnt == half)        cap_q[1] <= rxs;
            if (edge_cnt == half + 6'd1) cap_q[2] <= rxs;
        end
    end

    assign samp   = (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
    assign cnt_en = (state != IDLE);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            p_data      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            perr_q      <= 1'b0;
            shift_q     <= '0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            case (state)
                IDLE: begin
                    par_en_q  <= par_en;
                    par_typ_q <= par_typ;
                    perr_q    <= 1'b0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (bit_end) begin
                        if (samp) begin
                            strt_glitch <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        // LSB arrives first; after DATA_WIDTH shifts it sits at bit 0.
                        shift_q <= {samp, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_DATA) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        perr_q <= samp ^ (^shift_q) ^ par_typ_q;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        stp_err <= ~samp;
                        par_err <= perr_q;
                        if (samp && !perr_q) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: models the edge/bit counter, serializes frames onto rx_in
// and checks strobe counts and captured data against hand-computed values.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [3:0] bit_cnt;
    logic [5:0] edge_cnt;
    logic       cnt_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int ps    = 8;

    uart_rx_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .par_typ(par_typ), .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .cnt_en(cnt_en),
        .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
        .strt_glitch(strt_glitch), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge/bit counter model: clears while cnt_en is low, reads 0 when disabled.
    logic [3:0] bc_q;
    logic [5:0] ec_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc_q <= '0;
            ec_q <= '0;
        end else if (!cnt_en) begin
            bc_q <= '0;
            ec_q <= '0;
        end else if (ec_q == prescale - 6'd1) begin
            ec_q <= '0;
            bc_q <= bc_q + 4'd1;
        end else begin
            ec_q <= ec_q + 6'd1;
        end
    end
    assign bit_cnt  = cnt_en ? bc_q : 4'd0;
    assign edge_cnt = cnt_en ? ec_q : 6'd0;

    // Strobe monitor: running counts, last two published bytes, and over-wide strobes.
    int dv_n = 0, pe_n = 0, se_n = 0, gl_n = 0, wide_n = 0;
    logic [7:0] hist0 = 8'h00, hist1 = 8'h00;
    logic [3:0] prev_s = 4'b0;
    always @(negedge clk) begin
        if (data_valid) begin
            dv_n  <= dv_n + 1;
            hist1 <= hist0;
            hist0 <= p_data;
        end
        if (par_err)     pe_n <= pe_n + 1;
        if (stp_err)     se_n <= se_n + 1;
        if (strt_glitch) gl_n <= gl_n + 1;
        if (|(prev_s & {data_valid, par_err, stp_err, strt_glitch})) wide_n <= wide_n + 1;
        prev_s <= {data_valid, par_err, stp_err, strt_glitch};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bit time starting at a negedge; optional 1-clk inversion at offset 5..6.
    task automatic send_bit(input logic v, input bit gl);
        rx_in = v;
        for (int c = 1; c <= ps; c++) begin
            @(negedge clk);
            if (gl && c == 5)      rx_in = ~v;
            else if (gl && c == 6) rx_in = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_on, input logic par_bit,
                              input logic stop_bit, input int gl_idx);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gl_idx == i);
        if (par_on) send_bit(par_bit, 1'b0);
        send_bit(stop_bit, 1'b0);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ps(input int p);
        ps       = p;
        prescale = 6'(p);
    endtask

    int dv0, pe0, se0, gl0;
    task automatic snap();
        dv0 = dv_n; pe0 = pe_n; se0 = se_n; gl0 = gl_n;
    endtask

    initial begin
        rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
        set_ps(8);
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_cnt_en", 32'(cnt_en), 0);
        chk("rst_pdata",  32'(p_data), 0);
        chk("rst_strobe", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
        rst = 1'b1;
        idle(5);

        // 1: prescale 8, no parity, 0xA5
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle(3 * ps);
        chk("t1_dv",    32'(dv_n - dv0), 1);
        chk("t1_pdata", 32'(p_data), 32'hA5);
        chk("t1_errs",  32'((pe_n - pe0) + (se_n - se0) + (gl_n - gl0)), 0);
        chk("t1_busy",  32'(busy), 0);

        // 2: prescale 16, even parity; 0x3C has four ones so parity bit 0 is correct
        set_ps(16); par_en = 1'b1; par_typ = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
        idle(3 * ps);
        chk("t2a_dv",    32'(dv_n - dv0), 1);
        chk("t2a_pdata", 32'(p_data), 32'h3C);
        chk("t2a_perr",  32'(pe_n - pe0), 0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        idle(3 * ps);
        chk("t2b_perr",  32'(pe_n - pe0), 1);
        chk("t2b_dv",    32'(dv_n - dv0), 0);
        chk("t2b_serr",  32'(se_n - se0), 0);
        chk("t2b_pdata", 32'(p_data), 32'h3C);

        // 3: prescale 32, odd parity, 0x01 with correct parity 0, bad stop bit
        set_ps(32); par_typ = 1'b1;
        snap();
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
        idle(3 * ps);
        chk("t3_serr",  32'(se_n - se0), 1);
        chk("t3_dv",    32'(dv_n - dv0), 0);
        chk("t3_perr",  32'(pe_n - pe0), 0);
        chk("t3_pdata", 32'(p_data), 32'h3C);

        // 4: 3-clk low pulse at prescale 16
        set_ps(16); par_en = 1'b0; par_typ = 1'b0;
        snap();
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * ps);
        chk("t4_glitch", 32'(gl_n - gl0), 1);
        chk("t4_cnt_en", 32'(cnt_en), 0);
        chk("t4_busy",   32'(busy), 0);
        chk("t4_dv",     32'(dv_n - dv0), 0);

        // 5: back-to-back 0x55 (with 1-clk glitch in data bit 1) then 0xAA at prescale 8
        set_ps(8);
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1);
        idle(3 * ps);
        chk("t5_dv",    32'(dv_n - dv0), 2);
        chk("t5_first", 32'(hist1), 32'h55);
        chk("t5_second", 32'(hist0), 32'hAA);
        chk("t5_errs",  32'((pe_n - pe0) + (se_n - se0) + (gl_n - gl0)), 0);

        // 6: reset in the middle of 0x77, then a clean 0x12
        snap();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("t6_busy",   32'(busy), 0);
        chk("t6_cnt_en", 32'(cnt_en), 0);
        chk("t6_pdata",  32'(p_data), 0);
        chk("t6_strobe", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(20);
        chk("t6_nostrobe", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0) + (gl_n - gl0)), 0);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1);
        idle(3 * ps);
        chk("t6_dv",    32'(dv_n - dv0), 1);
        chk("t6_pdata", 32'(p_data), 32'h12);

        chk("strobe_width", 32'(wide_n), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
